data_mem_arbiter: RTL and testbench

Two-master arbiter that shares the single read/write port of the data memory subsystem (address1/data1/memWrite/qa side) between the CPU (master 0) and the image-processing engine (master 1). It issues at most one access per cycle, using round-robin with a bounded burst length. It tracks outstanding reads through the fixed synchronous read latency and routes each read return to the requester that issued it. Writes aimed at the read-only image ROM window are blocked and flagged.

---
 rtl/data_mem_arbiter_if.sv | 43 ++++
 rtl/data_mem_arbiter.sv | 153 +++++++++++++++
 tb/tb_data_mem_arbiter.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data memory port.
// The arbiter takes the slave view. The requesters and the memory model take the master view.
interface data_mem_arbiter_if;
    logic        m0_req;
    logic        m0_we;
    logic [19:0] m0_addr;
    logic [23:0] m0_wdata;
    logic        m0_gnt;
    logic        m0_rvalid;
    logic [23:0] m0_rdata;

    logic        m1_req;
    logic        m1_we;
    logic [19:0] m1_addr;
    logic [23:0] m1_wdata;
    logic        m1_gnt;
    logic        m1_rvalid;
    logic [23:0] m1_rdata;

    logic        mem_write;
    logic [19:0] mem_address;
    logic [23:0] mem_data;
    logic [23:0] mem_q;
    logic        wr_err;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        input  mem_q,
        output m0_gnt, m0_rvalid, m0_rdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output mem_write, mem_address, mem_data, wr_err
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        output mem_q,
        input  m0_gnt, m0_rvalid, m0_rdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  mem_write, mem_address, mem_data, wr_err
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// Two-master round-robin arbiter for the single data memory port.
// Bursts are bounded. Read returns are tagged back to their issuer.
// Writes into the image ROM window are dropped and flagged.
module data_mem_arbiter #(
    parameter int READ_LATENCY = 1,
    parameter int BURST_MAX    = 4,
    parameter int ROM_BASE     = 262220
) (
    input  logic              clk,
    input  logic              rst,
    data_mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} owner_t;

    localparam logic [3:0]  BURST_LIM = 4'(BURST_MAX);
    localparam logic [19:0] ROM_ADDR  = 20'(ROM_BASE);

    owner_t      owner_reg, owner_next;
    logic [3:0]  count_reg, count_next;
    logic        last_reg, last_next;

    logic        has_win;
    logic        win;
    logic        issue;
    logic        win_we;
    logic [19:0] win_addr;
    logic [23:0] win_data;
    logic        rom_hit;

    logic [19:0] addr_hold_reg;
    logic [23:0] data_hold_reg;
    logic        wr_err_reg;

    logic [READ_LATENCY-1:0] pipe_valid_reg, pipe_valid_next;
    logic [READ_LATENCY-1:0] pipe_tag_reg, pipe_tag_next;

    // Winner selection: round-robin on ties, bounded burst while contended
    always_comb begin
        has_win = 1'b0;
        win     = 1'b0;
        unique case (owner_reg)
            OWN0: begin
                if (bus.m0_req && (count_reg < BURST_LIM || !bus.m1_req)) begin
                    has_win = 1'b1;
                    win     = 1'b0;
                end else if (bus.m1_req) begin
                    has_win = 1'b1;
                    win     = 1'b1;
                end
            end
            OWN1: begin
                if (bus.m1_req && (count_reg < BURST_LIM || !bus.m0_req)) begin
                    has_win = 1'b1;
                    win     = 1'b1;
                end else if (bus.m0_req) begin
                    has_win = 1'b1;
                    win     = 1'b0;
                end
            end
            default: begin
                if (bus.m0_req && bus.m1_req) begin
                    has_win = 1'b1;
                    win     = ~last_reg;
                end else if (bus.m0_req || bus.m1_req) begin
                    has_win = 1'b1;
                    win     = bus.m1_req;
                end
            end
        endcase
    end

    // Reset kills an issue immediately, without waiting for an edge
    assign issue    = has_win & ~rst;
    assign win_we   = win ? bus.m1_we    : bus.m0_we;
    assign win_addr = win ? bus.m1_addr  : bus.m0_addr;
    assign win_data = win ? bus.m1_wdata : bus.m0_wdata;
    assign rom_hit  = (win_addr >= ROM_ADDR);

    assign bus.m0_gnt      = issue & ~win;
    assign bus.m1_gnt      = issue & win;
    assign bus.mem_write   = issue & win_we & ~rom_hit;
    assign bus.mem_address = issue ? win_addr : addr_hold_reg;
    assign bus.mem_data    = issue ? win_data : data_hold_reg;
    assign bus.wr_err      = wr_err_reg;

    // Next owner / burst count / last owner after this cycle
    always_comb begin
        owner_next = IDLE;
        count_next = 4'd0;
        last_next  = last_reg;
        if (issue) begin
            owner_next = win ? OWN1 : OWN0;
            last_next  = win;
            if ((owner_reg == OWN0 && !win) || (owner_reg == OWN1 && win)) begin
                count_next = (count_reg < BURST_LIM) ? count_reg + 4'd1 : count_reg;
            end else begin
                count_next = 4'd1;
            end
        end
    end

    // Arbitration state register; last_owner starts at 1 so master 0 wins the first tie
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_reg <= IDLE;
            count_reg <= 4'd0;
            last_reg  <= 1'b1;
        end else begin
            owner_reg <= owner_next;
            count_reg <= count_next;
            last_reg  <= last_next;
        end
    end

    // Hold the last issued address/data so an idle port does not toggle, and flag dropped ROM writes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_hold_reg <= 20'd0;
            data_hold_reg <= 24'd0;
            wr_err_reg    <= 1'b0;
        end else begin
            if (issue) begin
                addr_hold_reg <= win_addr;
                data_hold_reg <= win_data;
            end
            wr_err_reg <= issue & win_we & rom_hit;
        end
    end

    // Read-return pipe: stage 0 captures the issue, and the last stage lines up with mem_q
    assign pipe_valid_next[0] = issue & ~win_we;
    assign pipe_tag_next[0]   = win;
    for (genvar gi = 1; gi < READ_LATENCY; gi++) begin : g_pipe
        assign pipe_valid_next[gi] = pipe_valid_reg[gi-1];
        assign pipe_tag_next[gi]   = pipe_tag_reg[gi-1];
    end

    // Pipe register; reset discards every read still in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_valid_reg <= '0;
            pipe_tag_reg   <= '0;
        end else begin
            pipe_valid_reg <= pipe_valid_next;
            pipe_tag_reg   <= pipe_tag_next;
        end
    end

    assign bus.m0_rvalid = pipe_valid_reg[READ_LATENCY-1] & ~pipe_tag_reg[READ_LATENCY-1];
    assign bus.m1_rvalid = pipe_valid_reg[READ_LATENCY-1] &  pipe_tag_reg[READ_LATENCY-1];
    assign bus.m0_rdata  = bus.mem_q;
    assign bus.m1_rdata  = bus.mem_q;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: two instances (read latency 1 and 3) share one stimulus stream.
// Both are compared against a transaction-level arbitration model.
module tb_data_mem_arbiter;
    localparam int BMAX = 4;
    localparam int ROM  = 262220;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    data_mem_arbiter_if ifa();
    data_mem_arbiter_if ifb();

    data_mem_arbiter #(.READ_LATENCY(1), .BURST_MAX(BMAX), .ROM_BASE(ROM)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa)
    );
    data_mem_arbiter #(.READ_LATENCY(3), .BURST_MAX(BMAX), .ROM_BASE(ROM)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb)
    );

    logic        o_g0 [2], o_g1 [2], o_rv0 [2], o_rv1 [2], o_mw [2], o_err [2];
    logic [19:0] o_ma [2];
    logic [23:0] o_md [2], o_rd0 [2], o_rd1 [2];
    assign o_g0[0]  = ifa.m0_gnt;      assign o_g0[1]  = ifb.m0_gnt;
    assign o_g1[0]  = ifa.m1_gnt;      assign o_g1[1]  = ifb.m1_gnt;
    assign o_rv0[0] = ifa.m0_rvalid;   assign o_rv0[1] = ifb.m0_rvalid;
    assign o_rv1[0] = ifa.m1_rvalid;   assign o_rv1[1] = ifb.m1_rvalid;
    assign o_mw[0]  = ifa.mem_write;   assign o_mw[1]  = ifb.mem_write;
    assign o_err[0] = ifa.wr_err;      assign o_err[1] = ifb.wr_err;
    assign o_ma[0]  = ifa.mem_address; assign o_ma[1]  = ifb.mem_address;
    assign o_md[0]  = ifa.mem_data;    assign o_md[1]  = ifb.mem_data;
    assign o_rd0[0] = ifa.m0_rdata;    assign o_rd0[1] = ifb.m0_rdata;
    assign o_rd1[0] = ifa.m1_rdata;    assign o_rd1[1] = ifb.m1_rdata;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: who was granted last, how long the current run is, and a history of issues
    bit          m_active;
    bit          m_prev;
    int          m_streak;
    bit          hv [4];
    bit          ht [4];
    logic [19:0] ha [4];
    logic [19:0] last_addr;
    logic [23:0] last_data;
    bit          exp_err;

    bit          g_got, g_who;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [23:0] mem_model(input logic [19:0] a);
        return {4'h0, a} ^ 24'h0000F5;
    endfunction

    task automatic model_reset();
        m_active  = 1'b0;
        m_prev    = 1'b1;
        m_streak  = 0;
        for (int k = 0; k < 4; k++) begin
            hv[k] = 1'b0;
            ht[k] = 1'b0;
            ha[k] = '0;
        end
        last_addr = '0;
        last_data = '0;
        exp_err   = 1'b0;
    endtask

    task automatic drive(input logic r0, input logic w0, input logic [19:0] a0, input logic [23:0] d0,
                         input logic r1, input logic w1, input logic [19:0] a1, input logic [23:0] d1);
        ifa.m0_req = r0; ifa.m0_we = w0; ifa.m0_addr = a0; ifa.m0_wdata = d0;
        ifa.m1_req = r1; ifa.m1_we = w1; ifa.m1_addr = a1; ifa.m1_wdata = d1;
        ifb.m0_req = r0; ifb.m0_we = w0; ifb.m0_addr = a0; ifb.m0_wdata = d0;
        ifb.m1_req = r1; ifb.m1_we = w1; ifb.m1_addr = a1; ifb.m1_wdata = d1;
    endtask

    // One clock cycle: drive requests, compare every output to the model, then advance the model
    task automatic step(input logic r0, input logic w0, input logic [19:0] a0, input logic [23:0] d0,
                        input logic r1, input logic w1, input logic [19:0] a1, input logic [23:0] d1,
                        output bit got, output bit who);
        bit          hw, w, we;
        logic [19:0] a;
        logic [23:0] d;
        int          idx;
        string       p;
        @(negedge clk);
        drive(r0, w0, a0, d0, r1, w1, a1, d1);
        ifa.mem_q = hv[0] ? mem_model(ha[0]) : 24'($urandom);
        ifb.mem_q = hv[2] ? mem_model(ha[2]) : 24'($urandom);
        #1;
        hw = r0 | r1;
        if (r0 && r1) w = (!m_active || m_streak >= BMAX) ? ~m_prev : m_prev;
        else          w = r1;
        we = w ? w1 : w0;
        a  = w ? a1 : a0;
        d  = w ? d1 : d0;
        for (int i = 0; i < 2; i++) begin
            p   = (i == 0) ? "L1" : "L3";
            idx = (i == 0) ? 0 : 2;
            check({p, "_gnt0"}, 32'(o_g0[i]), 32'(hw & ~w));
            check({p, "_gnt1"}, 32'(o_g1[i]), 32'(hw & w));
            check({p, "_mem_write"}, 32'(o_mw[i]), 32'(hw & we & (a < ROM)));
            check({p, "_mem_address"}, 32'(o_ma[i]), 32'(hw ? a : last_addr));
            check({p, "_mem_data"}, 32'(o_md[i]), 32'(hw ? d : last_data));
            check({p, "_rvalid0"}, 32'(o_rv0[i]), 32'(hv[idx] & ~ht[idx]));
            check({p, "_rvalid1"}, 32'(o_rv1[i]), 32'(hv[idx] & ht[idx]));
            if (hv[idx] && !ht[idx]) check({p, "_rdata0"}, 32'(o_rd0[i]), 32'(mem_model(ha[idx])));
            if (hv[idx] && ht[idx])  check({p, "_rdata1"}, 32'(o_rd1[i]), 32'(mem_model(ha[idx])));
            check({p, "_wr_err"}, 32'(o_err[i]), 32'(exp_err));
        end
        if (hw)
            $display("cycle %0d: m%0d %s addr=%0d data=%06h", cyc, w, we ? "write" : "read", a, d);
        else
            $display("cycle %0d: idle", cyc);
        for (int k = 3; k > 0; k--) begin
            hv[k] = hv[k-1];
            ht[k] = ht[k-1];
            ha[k] = ha[k-1];
        end
        hv[0]   = hw & ~we;
        ht[0]   = w;
        ha[0]   = a;
        exp_err = hw & we & (a >= ROM);
        if (hw) begin
            m_streak  = (m_active && w == m_prev) ? ((m_streak + 1 > BMAX) ? BMAX : m_streak + 1) : 1;
            m_prev    = w;
            m_active  = 1'b1;
            last_addr = a;
            last_data = d;
        end else begin
            m_active = 1'b0;
            m_streak = 0;
        end
        got = hw;
        who = w;
        cyc++;
    endtask

    // Assert reset in the middle of a contended cycle; grants and writes must drop at once
    task automatic reset_mid();
        @(negedge clk);
        drive(1'b1, 1'b1, 20'd10, 24'h111111, 1'b1, 1'b1, 20'd20, 24'h222222);
        #1 rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            check("rst_gnt0", 32'(o_g0[i]), 32'd0);
            check("rst_gnt1", 32'(o_g1[i]), 32'd0);
            check("rst_mem_write", 32'(o_mw[i]), 32'd0);
            check("rst_rvalid0", 32'(o_rv0[i]), 32'd0);
            check("rst_rvalid1", 32'(o_rv1[i]), 32'd0);
        end
        $display("cycle %0d: reset asserted", cyc);
        model_reset();
        drive(1'b0, 1'b0, 20'd0, 24'd0, 1'b0, 1'b0, 20'd0, 24'd0);
        @(negedge clk);
        rst = 1'b0;
        cyc++;
    endtask

    function automatic logic [19:0] pick_addr();
        case ($urandom_range(0, 4))
            0:       return 20'(ROM);
            1:       return 20'(ROM - 1);
            2:       return 20'(ROM + $urandom_range(0, 100));
            3:       return 20'($urandom_range(0, 255));
            default: return 20'($urandom);
        endcase
    endfunction

    logic        p0, pw0, p1, pw1;
    logic [19:0] pa0, pa1;
    logic [23:0] pd0, pd1;

    initial begin
        model_reset();
        drive(1'b0, 1'b0, 20'd0, 24'd0, 1'b0, 1'b0, 20'd0, 24'd0);
        ifa.mem_q = '0;
        ifb.mem_q = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // reset state with no requests
        step(0, 0, 0, 0, 0, 0, 0, 0, g_got, g_who);
        // single read from m0 at addr 80, memory returns 0x0000A5
        step(1, 0, 20'd80, 0, 0, 0, 0, 0, g_got, g_who);
        repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0, g_got, g_who);
        // after an idle gap both request: master 0 was last owner, so m1 wins first
        repeat (2) step(1, 0, 20'd5, 0, 1, 0, 20'd6, 0, g_got, g_who);
        // sustained contention: bursts of BMAX
        repeat (12) step(1, 0, 20'd7, 24'h0A0A0A, 1, 1, 20'd8, 24'h0B0B0B, g_got, g_who);
        // lone m1 for 10 cycles
        repeat (10) step(0, 0, 0, 0, 1, 0, 20'd300, 0, g_got, g_who);
        step(0, 0, 0, 0, 0, 0, 0, 0, g_got, g_who);
        // ROM window boundary writes
        step(1, 1, 20'(ROM), 24'h123456, 0, 0, 0, 0, g_got, g_who);
        step(1, 1, 20'(ROM - 1), 24'h123456, 0, 0, 0, 0, g_got, g_who);
        repeat (2) step(0, 0, 0, 0, 0, 0, 0, 0, g_got, g_who);
        // reads outstanding when reset hits
        step(1, 0, 20'd40, 0, 0, 0, 0, 0, g_got, g_who);
        step(0, 0, 0, 0, 1, 0, 20'd41, 0, g_got, g_who);
        reset_mid();
        step(0, 0, 0, 0, 0, 0, 0, 0, g_got, g_who);
        step(1, 0, 20'd1, 0, 1, 0, 20'd2, 0, g_got, g_who);
        step(1, 0, 20'd1, 0, 1, 0, 20'd2, 0, g_got, g_who);

        // randomized traffic; requests are held until granted, with occasional withdrawal
        p0 = 0; p1 = 0; pw0 = 0; pw1 = 0; pa0 = 0; pa1 = 0; pd0 = 0; pd1 = 0;
        for (int n = 0; n < 400; n++) begin
            if (!p0 && $urandom_range(0, 99) < 60) begin
                p0 = 1; pw0 = ($urandom_range(0, 2) == 0); pa0 = pick_addr(); pd0 = 24'($urandom);
            end else if (p0 && $urandom_range(0, 99) < 5) begin
                p0 = 0;
            end
            if (!p1 && $urandom_range(0, 99) < 60) begin
                p1 = 1; pw1 = ($urandom_range(0, 2) == 0); pa1 = pick_addr(); pd1 = 24'($urandom);
            end else if (p1 && $urandom_range(0, 99) < 5) begin
                p1 = 0;
            end
            step(p0, pw0, pa0, pd0, p1, pw1, pa1, pd1, g_got, g_who);
            if (g_got && !g_who) p0 = 0;
            if (g_got && g_who)  p1 = 0;
            if (n == 200) begin
                reset_mid();
                p0 = 0;
                p1 = 0;
            end
        end
        repeat (4) step(0, 0, 0, 0, 0, 0, 0, 0, g_got, g_who);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
